fetch_unit: RTL

Parametrised instruction-fetch front end that replaces the bare PC register, PC+4 incrementer and direct instruction-memory read of the single-cycle core. It issues sequential fetch requests to instruction memory over a valid/ready request channel with an in-order, variable-latency response channel. It buffers returned instructions with their PCs in a prefetch queue and hands them to decode over a valid/ready handshake. A redirect port (branch/jump from the ALU path) flushes the queue and drops in-flight responses.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Purpose     : generic synchronous FIFO with flush, used here as the fetch prefetch queue.
// Latency     : an entry pushed at edge N is at the head from cycle N+1; the head is a direct read.
// Backpressure: the caller never pushes when full nor pops when empty; flush outranks push/pop.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_rdy,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop_rdy})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: an entry is only observed once count covers it.
    always_ff @(posedge clock) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Purpose     : instruction-fetch front end: sequential imem requests, prefetch queue, redirect flush.
// Latency     : request accepted at N, response at N+L, inst_valid at N+L+1 (no response bypass).
// Backpressure: requests are only issued while queue entries plus live in-flight requests < QUEUE_DEPTH.
// Ports: clock/reset_n (sync, active-low); imem_req_* request channel; imem_resp_* in-order responses;
//        redirect_valid/redirect_pc flush and restart; inst_* decode handshake; queue_count occupancy.
module fetch_unit #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               QUEUE_DEPTH  = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    output logic                           imem_req_valid,
    input  logic                           imem_req_ready,
    output logic [XLEN-1:0]                imem_req_addr,
    input  logic                           imem_resp_valid,
    input  logic [31:0]                    imem_resp_data,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [31:0]                    inst_data,
    output logic [XLEN-1:0]                inst_pc,
    output logic [XLEN-1:0]                inst_pc_next,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);
    localparam int              CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_base;
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    entry_t          push_entry;
    entry_t          head_entry;
    logic            redirect_lsb_unused;

    assign redirect_base       = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // A response with nothing outstanding is spurious and ignored outright.
    assign resp_fire = imem_resp_valid && (outstanding != '0);

    // Credit counts queued entries plus in-flight requests whose data will be kept;
    // drop never exceeds outstanding, so the subtraction cannot wrap.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding - drop};
    assign imem_req_valid = reset_n && !redirect_valid &&
                            (credit_used < DEPTH_W) && (outstanding < DEPTH_C);
    assign imem_req_addr  = reset_n ? fetch_pc : RESET_VECTOR;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push       = resp_fire && !redirect_valid && (drop == '0);
    assign push_entry = {resp_pc, imem_resp_data};
    assign inst_valid = reset_n && !redirect_valid && (count != '0);
    assign pop        = inst_valid && inst_ready;

    fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_rdy  (pop),
        .head_dat (head_entry),
        .count    (count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            case ({req_fire, resp_fire})
                2'b10:   outstanding <= outstanding + ONE;
                2'b01:   outstanding <= outstanding - ONE;
                default: outstanding <= outstanding;
            endcase
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                // A response arriving alongside the redirect is already discarded here.
                drop     <= resp_fire ? outstanding - ONE : outstanding;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (resp_fire) begin
                    if (drop != '0) drop <= drop - ONE;
                    else            resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

    assign inst_data    = reset_n ? head_entry.data : '0;
    assign inst_pc      = reset_n ? head_entry.pc   : '0;
    assign inst_pc_next = inst_pc + PC_STEP;
    assign queue_count  = reset_n ? count : '0;
endmodule
